// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and width/resize helpers for the arithmetic blocks
package addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int SAT_W       = 64;
    localparam int MAX_LATENCY = 8;

    function automatic int full_width(int d0, int d1, bit s0, bit s1);
        return ((d0 > d1) ? d0 : d1) + 1 + ((s0 ^ s1) ? 1 : 0);
    endfunction

    // value must already be the exact result extended to SAT_W per rs
    function automatic logic [SAT_W-1:0] sat_resize(logic [SAT_W-1:0] value, int fw, int dout, bit rs);
        logic signed [SAT_W-1:0] v_s;
        logic signed [SAT_W-1:0] v_max;
        logic signed [SAT_W-1:0] v_min;
        logic        [SAT_W-1:0] u_max;
        v_s   = signed'(value);
        v_max = signed'((SAT_W'(1) << (dout - 1)) - SAT_W'(1));
        v_min = ~v_max;
        u_max = (SAT_W'(1) << dout) - SAT_W'(1);
        if (dout >= fw) begin
            return value;
        end
        if (rs) begin
            if (v_s > v_max) begin
                return $unsigned(v_max);
            end
            if (v_s < v_min) begin
                return $unsigned(v_min);
            end
            return value;
        end
        return (value > u_max) ? u_max : value;
    endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// rtl/addsub_pipe_if.sv - DTI valid/ready/data stream interface
interface dti #(
    parameter int W = 16
) ();
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport producer (output data, output valid, input ready);
    modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/addsub_pipe_stage.sv
// rtl/addsub_pipe_stage.sv - two-entry elastic register stage with registered ready
module dti_skid_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);
    logic         r_main_valid;
    logic         r_skid_valid;
    logic         r_ready;
    logic [W-1:0] r_main_data;
    logic [W-1:0] r_skid_data;
    logic         w_take;
    logic         w_adv;

    assign w_take  = i_valid & r_ready;
    assign w_adv   = ~r_main_valid | i_ready;
    assign o_ready = r_ready;
    assign o_valid = r_main_valid;
    assign o_data  = r_main_data;

    // ready only drops once the skid slot has caught the item in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else begin
            if (w_adv) begin
                if (r_skid_valid) begin
                    r_main_valid <= 1'b1;
                    r_main_data  <= r_skid_data;
                    r_skid_valid <= 1'b0;
                end else begin
                    r_main_valid <= w_take;
                    if (w_take) begin
                        r_main_data <= i_data;
                    end
                end
                r_ready <= 1'b1;
            end else begin
                if (w_take) begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= i_data;
                end
                r_ready <= ~(r_skid_valid | w_take);
            end
        end
    end

endmodule

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - joined two-operand add/subtract with resize and elastic output pipe
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int DIN0        = 16,
    parameter int DIN1        = 16,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 0,
    parameter int OP          = 1,
    parameter int DOUT        = 0,
    parameter int SATURATE    = 0,
    parameter int LATENCY     = 1
) (
    input  logic clk,
    input  logic rst,
    dti.consumer din0,
    dti.consumer din1,
    dti.producer dout
);
    localparam bit  RS   = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0) || (OP != 0);
    localparam int  FW   = full_width(DIN0, DIN1, DIN0_SIGNED != 0, DIN1_SIGNED != 0);
    localparam int  OW   = (DOUT == 0) ? FW : DOUT;
    localparam op_e OPER = (OP != 0) ? OP_SUB : OP_ADD;

    logic [FW-1:0] w_a;
    logic [FW-1:0] w_b;
    logic [FW-1:0] w_full;
    logic [OW-1:0] w_res;
    logic          w_jvalid;
    logic          w_jready;

    assign w_jvalid   = din0.valid & din1.valid;
    assign din0.ready = w_jvalid & w_jready;
    assign din1.ready = w_jvalid & w_jready;

    // FW is wide enough that the arithmetic below is exact
    always_comb begin
        w_a    = {{(FW - DIN0){(DIN0_SIGNED != 0) && din0.data[DIN0-1]}}, din0.data};
        w_b    = {{(FW - DIN1){(DIN1_SIGNED != 0) && din1.data[DIN1-1]}}, din1.data};
        w_full = (OPER == OP_SUB) ? (w_a - w_b) : (w_a + w_b);
        if (SATURATE != 0) begin
            w_res = OW'(sat_resize({{(SAT_W - FW){RS && w_full[FW-1]}}, w_full}, FW, OW, RS));
        end else begin
            w_res = OW'({{(SAT_W - FW){RS && w_full[FW-1]}}, w_full});
        end
    end

    generate
        if (LATENCY == 0) begin : g_comb
            assign dout.valid = w_jvalid & ~rst;
            assign dout.data  = w_res;
            assign w_jready   = dout.ready & ~rst;
        end else begin : g_pipe
            logic [OW-1:0] w_sdata  [0:LATENCY];
            logic          w_svalid [0:LATENCY];
            logic          w_sready [0:LATENCY];

            assign w_sdata[0]        = w_res;
            assign w_svalid[0]       = w_jvalid;
            assign w_jready          = w_sready[0];
            assign w_sready[LATENCY] = dout.ready;
            assign dout.valid        = w_svalid[LATENCY];
            assign dout.data         = w_sdata[LATENCY];

            for (genvar g = 0; g < LATENCY; g++) begin : g_stage
                dti_skid_stage #(.W(OW)) u_stage (
                    .clk     (clk),
                    .rst     (rst),
                    .i_data  (w_sdata[g]),
                    .i_valid (w_svalid[g]),
                    .o_ready (w_sready[g]),
                    .o_data  (w_sdata[g+1]),
                    .o_valid (w_svalid[g+1]),
                    .i_ready (w_sready[g+1])
                );
            end
        end
    endgenerate

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - directed vector bench for addsub_pipe
module tb_addsub_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] r_a, r_b, r4_a, r4_b;
    logic       r_v, r4_av, r4_bv, r4_rdy;

    dti #(.W(8))  a0 ();
    dti #(.W(8))  b0 ();
    dti #(.W(9))  o0 ();
    dti #(.W(8))  a1 ();
    dti #(.W(8))  b1 ();
    dti #(.W(10)) o1 ();
    dti #(.W(8))  a2 ();
    dti #(.W(8))  b2 ();
    dti #(.W(8))  o2 ();
    dti #(.W(8))  a3 ();
    dti #(.W(8))  b3 ();
    dti #(.W(8))  o3 ();
    dti #(.W(8))  a4 ();
    dti #(.W(8))  b4 ();
    dti #(.W(9))  o4 ();

    assign a0.data = r_a;  assign a0.valid = r_v;  assign b0.data = r_b;  assign b0.valid = r_v;
    assign a1.data = r_a;  assign a1.valid = r_v;  assign b1.data = r_b;  assign b1.valid = r_v;
    assign a2.data = r_a;  assign a2.valid = r_v;  assign b2.data = r_b;  assign b2.valid = r_v;
    assign a3.data = r_a;  assign a3.valid = r_v;  assign b3.data = r_b;  assign b3.valid = r_v;
    assign a4.data = r4_a; assign a4.valid = r4_av; assign b4.data = r4_b; assign b4.valid = r4_bv;
    assign o0.ready = 1'b1;
    assign o1.ready = 1'b1;
    assign o2.ready = 1'b1;
    assign o3.ready = 1'b1;
    assign o4.ready = r4_rdy;

    addsub_pipe #(.DIN0(8), .DIN1(8), .DIN0_SIGNED(0), .DIN1_SIGNED(0), .OP(1), .DOUT(0),
                  .SATURATE(0), .LATENCY(2)) u0 (.clk(clk), .rst(rst), .din0(a0), .din1(b0), .dout(o0));
    addsub_pipe #(.DIN0(8), .DIN1(8), .DIN0_SIGNED(1), .DIN1_SIGNED(0), .OP(0), .DOUT(0),
                  .SATURATE(0), .LATENCY(1)) u1 (.clk(clk), .rst(rst), .din0(a1), .din1(b1), .dout(o1));
    addsub_pipe #(.DIN0(8), .DIN1(8), .DIN0_SIGNED(1), .DIN1_SIGNED(1), .OP(1), .DOUT(8),
                  .SATURATE(1), .LATENCY(1)) u2 (.clk(clk), .rst(rst), .din0(a2), .din1(b2), .dout(o2));
    addsub_pipe #(.DIN0(8), .DIN1(8), .DIN0_SIGNED(1), .DIN1_SIGNED(1), .OP(1), .DOUT(8),
                  .SATURATE(0), .LATENCY(0)) u3 (.clk(clk), .rst(rst), .din0(a3), .din1(b3), .dout(o3));
    addsub_pipe #(.DIN0(8), .DIN1(8), .DIN0_SIGNED(0), .DIN1_SIGNED(0), .OP(0), .DOUT(0),
                  .SATURATE(0), .LATENCY(3)) u4 (.clk(clk), .rst(rst), .din0(a4), .din1(b4), .dout(o4));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [9:0] e0;
        logic [9:0] e1;
        logic [7:0] e2;
        logic [7:0] e3;
    } vec_t;

    vec_t       tv [10];
    logic [9:0] q0 [$];
    logic [9:0] q1 [$];
    logic [9:0] q2 [$];
    logic [9:0] q3 [$];
    logic [9:0] q4 [$];
    int         n_vec = 0;
    int         n_err = 0;
    int         stab_err = 0;
    logic       p_v = 1'b0;
    logic       p_r = 1'b0;
    logic [8:0] p_d = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] item_a(input int i);
        return 8'(i * 11 + 3);
    endfunction

    function automatic logic [7:0] item_b(input int i);
        return 8'(i * 29 + 100);
    endfunction

    task automatic drive_item(input int i);
        r4_a = item_a(i);
        r4_b = item_b(i);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o0.valid && o0.ready) q0.push_back(10'(o0.data));
            if (o1.valid && o1.ready) q1.push_back(o1.data);
            if (o2.valid && o2.ready) q2.push_back(10'(o2.data));
            if (o3.valid && o3.ready) q3.push_back(10'(o3.data));
            if (o4.valid && o4.ready) q4.push_back(10'(o4.data));
            if (p_v && !p_r && (!o4.valid || o4.data !== p_d)) stab_err++;
            p_v = o4.valid;
            p_r = o4.ready;
            p_d = o4.data;
        end else begin
            p_v = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx;
        int   cyc;
        logic hs;
        logic rdy_seen;

        tv[0] = '{8'h05, 8'h07, 10'h1FE, 10'h00C, 8'hFE, 8'hFE};
        tv[1] = '{8'hC8, 8'h00, 10'h0C8, 10'h3C8, 8'hC8, 8'hC8};
        tv[2] = '{8'h80, 8'hFF, 10'h181, 10'h07F, 8'h81, 8'h81};
        tv[3] = '{8'h80, 8'h00, 10'h080, 10'h380, 8'h80, 8'h80};
        tv[4] = '{8'h80, 8'h01, 10'h07F, 10'h381, 8'h80, 8'h7F};
        tv[5] = '{8'h7F, 8'hFF, 10'h180, 10'h17E, 8'h7F, 8'h80};
        tv[6] = '{8'hFF, 8'hFF, 10'h000, 10'h0FE, 8'h00, 8'h00};
        tv[7] = '{8'h00, 8'hFF, 10'h101, 10'h0FF, 8'h01, 8'h01};
        tv[8] = '{8'h7F, 8'h80, 10'h1FF, 10'h0FF, 8'h7F, 8'hFF};
        tv[9] = '{8'h80, 8'h7F, 10'h001, 10'h3FF, 8'h80, 8'h01};

        r_a = '0; r_b = '0; r_v = 1'b0;
        r4_a = '0; r4_b = '0; r4_av = 1'b0; r4_bv = 1'b0; r4_rdy = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        r_v = 1'b1; r4_av = 1'b1; r4_bv = 1'b1;
        #1;
        check("rst_din0_ready_u0", a0.ready, 0);
        check("rst_din1_ready_u4", b4.ready, 0);
        check("rst_din0_ready_u3", a3.ready, 0);
        check("rst_dout_valid_u3", o3.valid, 0);
        check("rst_dout_valid_u4", o4.valid, 0);
        r_v = 1'b0;
        rst = 1'b0;
        #1;
        check("release_ready_before_clk_u4", a4.ready, 0);
        @(posedge clk);
        #1;
        check("release_ready_after_clk_u4", a4.ready, 1);
        check("release_dout_valid_u0", o0.valid, 0);
        r4_av = 1'b0; r4_bv = 1'b0;

        // latency
        r_a = 8'd5; r_b = 8'd7; r_v = 1'b1;
        @(posedge clk);
        #1;
        r_v = 1'b0;
        check("lat1_valid_u1", o1.valid, 1);
        check("lat_early_valid_u0", o0.valid, 0);
        @(posedge clk);
        #1;
        check("lat2_valid_u0", o0.valid, 1);
        check("lat2_data_u0", o0.data, 9'h1FE);
        repeat (4) @(posedge clk);
        #1;
        q0.delete(); q1.delete(); q2.delete(); q3.delete(); q4.delete();

        // table vectors, one per cycle, all sinks always ready
        for (int i = 0; i < 10; i++) begin
            r_a = tv[i].a; r_b = tv[i].b; r_v = 1'b1;
            @(posedge clk);
            #1;
        end
        r_v = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("tbl_count_u0", q0.size(), 10);
        check("tbl_count_u1", q1.size(), 10);
        check("tbl_count_u2", q2.size(), 10);
        check("tbl_count_u3", q3.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < q0.size()) check($sformatf("tbl_u0_sub_v%0d", i), q0[i], tv[i].e0);
            if (i < q1.size()) check($sformatf("tbl_u1_mix_v%0d", i), q1[i], tv[i].e1);
            if (i < q2.size()) check($sformatf("tbl_u2_sat_v%0d", i), q2[i], 10'(tv[i].e2));
            if (i < q3.size()) check($sformatf("tbl_u3_wrap_v%0d", i), q3[i], 10'(tv[i].e3));
        end
        q0.delete(); q1.delete(); q2.delete(); q3.delete();

        // join: din0 alone must not be consumed
        r4_rdy = 1'b1; r4_a = 8'd10; r4_b = 8'd20; r4_av = 1'b1; r4_bv = 1'b0; rdy_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (a4.ready || b4.ready) rdy_seen = 1'b1;
        end
        check("join_no_ready_alone", rdy_seen, 0);
        @(posedge clk);
        #1;
        r4_bv = 1'b1;
        @(negedge clk);
        check("join_ready_both", a4.ready, 1);
        @(posedge clk);
        #1;
        r4_av = 1'b0; r4_bv = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("join_out_count", q4.size(), 1);
        if (q4.size() > 0) check("join_out_data", q4[0], 10'd30);
        q4.delete();

        // backpressure: full stall, then random sink
        idx = 0; r4_rdy = 1'b0; drive_item(0); r4_av = 1'b1; r4_bv = 1'b1;
        repeat (20) begin
            @(negedge clk);
            hs = a4.ready;
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                drive_item(idx);
            end
        end
        check("stall_accepted", idx, 6);
        cyc = 0;
        while (idx < 20 && cyc < 2000) begin
            r4_rdy = ($urandom_range(0, 99) < 30);
            @(negedge clk);
            hs = a4.ready;
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                if (idx < 20) drive_item(idx);
            end
            cyc++;
        end
        r4_av = 1'b0; r4_bv = 1'b0;
        check("bp_all_sent", idx, 20);
        cyc = 0;
        while (q4.size() < 20 && cyc < 200) begin
            r4_rdy = ($urandom_range(0, 99) < 30);
            @(posedge clk);
            #1;
            cyc++;
        end
        r4_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("bp_out_count", q4.size(), 20);
        for (int i = 0; i < 20; i++) begin
            if (i < q4.size()) check($sformatf("bp_item%0d", i), q4[i], {2'b00, item_a(i)} + {2'b00, item_b(i)});
        end
        check("bp_hold_stable", stab_err, 0);
        q4.delete();

        // asynchronous reset with items in flight
        idx = 0; cyc = 0; r4_rdy = 1'b0; drive_item(0); r4_av = 1'b1; r4_bv = 1'b1;
        while (idx < 4 && cyc < 50) begin
            @(negedge clk);
            hs = a4.ready;
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                drive_item(idx);
            end
            cyc++;
        end
        r4_av = 1'b0; r4_bv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_inflight_valid", o4.valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid_drop", o4.valid, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        r4_rdy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rst_mid_no_stale", q4.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
